booth_mul_arbiter: RTL and testbench

Round-robin arbiter that shares one radix-4 Booth multiplier (start/done sequenced, 8x8 signed → 16-bit product) among NREQ requesters. It latches the winning requester's operands, pulses the multiplier start, waits for done, and returns the product to that requester with a one-cycle acknowledge. A watchdog bounds each operation so a stalled multiplier cannot hang the requesters. It sits between the requester ports and the single multiplier instance.

---
 rtl/booth_mul_arbiter.sv | 111 +++++++++++
 tb/tb_booth_mul_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter that time-shares one start/done sequenced multiplier
// among NREQ requesters, with a watchdog bounding each multiply.
module booth_mul_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   q_in,
  input  logic [NREQ*WIDTH-1:0]   m_in,
  output logic [NREQ-1:0]         ack,
  output logic [2*WIDTH-1:0]      result,
  output logic                    err,
  output logic                    busy,
  output logic                    mul_start,
  output logic [WIDTH-1:0]        mul_q,
  output logic [WIDTH-1:0]        mul_m,
  input  logic                    mul_done,
  input  logic [2*WIDTH-1:0]      mul_product
);

  localparam int GW  = $clog2(NREQ);
  localparam int WDW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;
  state_t state, state_nx;

  logic [NREQ-1:0][WIDTH-1:0] q_lane, m_lane;
  logic [GW-1:0]  last, grant, win, idx;
  logic [WDW-1:0] wd;
  logic           any_req, timeout;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign q_lane[i] = q_in[i*WIDTH +: WIDTH];
    assign m_lane[i] = m_in[i*WIDTH +: WIDTH];
  end

  assign any_req = |req;
  assign timeout = (wd == WDW'(TIMEOUT - 1));

  // Scan from farthest to nearest so the closest requester after 'last' wins.
  always_comb begin
    win = last;
    idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = GW'((int'(last) + k) % NREQ);
      if (req[idx]) win = idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = START;
      START:   state_nx = WAIT;
      WAIT:    if (mul_done || timeout) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last      <= GW'(NREQ - 1);
      grant     <= '0;
      wd        <= '0;
      ack       <= '0;
      result    <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
      mul_start <= 1'b0;
      mul_q     <= '0;
      mul_m     <= '0;
    end else begin
      ack       <= '0;
      mul_start <= (state == IDLE) && any_req;
      busy      <= (state_nx != IDLE);
      case (state)
        IDLE: if (any_req) begin
          grant <= win;
          mul_q <= q_lane[win];
          mul_m <= m_lane[win];
        end
        START: wd <= '0;
        WAIT: begin
          wd <= wd + 1'b1;
          // A done arriving on the timeout cycle still delivers its product.
          if (mul_done) begin
            result <= mul_product;
            err    <= 1'b0;
            ack    <= NREQ'(1) << grant;
          end else if (timeout) begin
            result <= '0;
            err    <= 1'b1;
            ack    <= NREQ'(1) << grant;
          end
        end
        RESP: last <= grant;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Randomized bench for booth_mul_arbiter: transaction-level reference model,
// per-cycle output comparison, plus directed scenarios with literal checks.
module tb_booth_mul_arbiter;
  localparam int NREQ = 4, W = 8, TO = 64;

  logic             clk = 1'b0, rst_n = 1'b0;
  logic [NREQ-1:0]  req = '0;
  logic [NREQ*W-1:0] q_in = '0, m_in = '0;
  logic [NREQ-1:0]  ack;
  logic [2*W-1:0]   result, mul_product = '0;
  logic             err, busy, mul_start, mul_done = 1'b0;
  logic [W-1:0]     mul_q, mul_m;

  booth_mul_arbiter #(.NREQ(NREQ), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .q_in(q_in), .m_in(m_in),
    .ack(ack), .result(result), .err(err), .busy(busy),
    .mul_start(mul_start), .mul_q(mul_q), .mul_m(mul_m),
    .mul_done(mul_done), .mul_product(mul_product));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction timestamps) ----------------
  logic [NREQ-1:0] e_ack = '0;
  logic [2*W-1:0]  e_res = '0;
  logic            e_err = 1'b0, e_busy = 1'b0, e_start = 1'b0;
  logic [W-1:0]    e_q = '0, e_m = '0;

  function automatic int rr_pick(input int lst, input logic [NREQ-1:0] r);
    for (int k = 1; k <= NREQ; k++)
      if (r[(lst + k) % NREQ]) return (lst + k) % NREQ;
    return -1;
  endfunction

  initial begin
    int cyc = 0, m_last = NREQ - 1, m_grant = 0, m_gedge = 0, m_fedge = -1, k = 0;
    bit m_active = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_active = 0; m_last = NREQ - 1;
        e_ack = '0; e_res = '0; e_err = 0; e_busy = 0; e_start = 0; e_q = '0; e_m = '0;
      end else begin
        cyc++;
        e_start = 0; e_ack = '0;
        if (!m_active) begin
          if (req != '0) begin
            m_grant = rr_pick(m_last, req);
            m_active = 1; m_gedge = cyc; m_fedge = -1;
            e_q = q_in[m_grant*W +: W]; e_m = m_in[m_grant*W +: W];
            e_start = 1; e_busy = 1;
          end
        end else if (m_fedge < 0) begin
          // the multiplier is listened to from the second edge after the grant
          if (cyc >= m_gedge + 2) begin
            k = cyc - m_gedge - 1;
            if (mul_done) begin
              e_res = mul_product; e_err = 0; m_fedge = cyc;
            end else if (k == TO) begin
              e_res = '0; e_err = 1; m_fedge = cyc;
            end
            if (m_fedge == cyc) e_ack = NREQ'(1) << m_grant;
          end
        end else begin
          m_active = 0; m_last = m_grant; e_busy = 0;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("ack", 32'(ack), 32'(e_ack));
    chk("result", 32'(result), 32'(e_res));
    chk("err", 32'(err), 32'(e_err));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("mul_start", 32'(mul_start), 32'(e_start));
    chk("mul_q", 32'(mul_q), 32'(e_q));
    chk("mul_m", 32'(mul_m), 32'(e_m));
  end

  // ---------------- environment: multiplier + requesters ----------------
  int ackq[$];
  logic [2*W-1:0] resq[$];
  logic errq[$];
  int nstart = 0, scyc = 0, st_cyc = 0, ak_cyc = 0, lat_cfg = 2;
  bit lat_rand = 0, rand_en = 0, spur_en = 0;
  bit [NREQ-1:0] persist = '0;

  initial begin
    int mcnt = 0, a = 0, b = 0, lat = 0;
    logic [2*W-1:0] cur = '0;
    forever begin
      @(posedge clk); #1;
      scyc++;
      mul_done = 0;
      mul_product = 16'($urandom);
      if (!rst_n) mcnt = 0;
      else begin
        if (mul_start) begin
          nstart++; st_cyc = scyc;
          a = $signed(mul_q); b = $signed(mul_m);
          cur = 16'(a * b);
          lat = lat_rand ? (($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 6))) : lat_cfg;
          mcnt = lat;
        end else if (mcnt > 0) begin
          mcnt--;
          if (mcnt == 0) begin mul_done = 1; mul_product = cur; end
        end else if (spur_en && !busy && $urandom_range(0, 2) == 0) begin
          mul_done = 1;
        end
        for (int i = 0; i < NREQ; i++) begin
          if (ack[i]) begin
            ackq.push_back(i); resq.push_back(result); errq.push_back(err);
            ak_cyc = scyc; req[i] = 0;
          end else if (!req[i] && (persist[i] || (rand_en && $urandom_range(0, 3) == 0))) begin
            q_in[i*W +: W] = 8'($urandom); m_in[i*W +: W] = 8'($urandom);
            req[i] = 1;
          end
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  task automatic step(); @(posedge clk); #3; endtask

  task automatic wait_acks(input int target, input int budget, input string nm);
    int c = 0;
    while (ackq.size() < target && c < budget) begin step(); c++; end
    chk({nm, "_ack_wait"}, 32'(ackq.size() >= target), 32'd1);
  endtask

  task automatic drain(input int budget);
    int c = 0;
    while ((req != '0 || busy) && c < budget) begin step(); c++; end
    chk("drain", 32'(req == '0 && !busy), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk); #2 rst_n = 0; req = '0;
    repeat (2) step();
    rst_n = 1;
  endtask

  initial begin
    int base = 0, ns0 = 0, c = 0;
    step();
    chk("rst_ack", 32'(ack), 0); chk("rst_busy", 32'(busy), 0);
    chk("rst_start", 32'(mul_start), 0); chk("rst_result", 32'(result), 0);
    repeat (2) step();
    rst_n = 1;
    step();

    // single request: 7 * 6, done 5 cycles after start
    lat_cfg = 5; q_in[7:0] = 8'd7; m_in[7:0] = 8'd6; req = 4'b0001;
    wait_acks(1, 40, "single");
    chk("single_lane", 32'(ackq[0]), 0); chk("single_res", 32'(result), 32'd42);
    chk("single_err", 32'(err), 0); chk("single_starts", 32'(nstart), 1);
    chk("single_q", 32'(mul_q), 7); chk("single_m", 32'(mul_m), 6);

    // contention from reset pointer: order 0,1,2,3
    do_reset();
    lat_cfg = 2;
    for (int i = 0; i < NREQ; i++) begin
      q_in[i*W +: W] = 8'(10 + i); m_in[i*W +: W] = 8'(20 + i);
    end
    base = ackq.size(); ns0 = nstart; req = 4'b1111;
    wait_acks(base + 4, 100, "contend");
    for (int i = 0; i < NREQ; i++) begin
      chk("contend_order", 32'(ackq[base+i]), 32'(i));
      chk("contend_res", 32'(resq[base+i]), 32'((10 + i) * (20 + i)));
    end
    chk("contend_starts", 32'(nstart - ns0), 4);

    // fairness: 0 and 2 re-request right after every ack
    base = ackq.size(); persist = 4'b0101;
    wait_acks(base + 8, 200, "fair");
    for (int i = 0; i < 8; i++) chk("fair_order", 32'(ackq[base+i]), (i % 2 == 0) ? 0 : 2);
    persist = '0;
    drain(100);

    // spurious done while idle, then signed pass-through
    spur_en = 1; base = ackq.size();
    repeat (12) step();
    chk("spur_no_ack", 32'(ackq.size()), 32'(base));
    lat_cfg = 3; q_in[15:8] = 8'hFD; m_in[15:8] = 8'h05; req[1] = 1;
    wait_acks(base + 1, 40, "signed");
    chk("signed_lane", 32'(ackq[base]), 1); chk("signed_res", 32'(result), 32'hFFF1);
    spur_en = 0;
    drain(20);

    // timeout: multiplier never answers
    lat_cfg = 0; base = ackq.size(); q_in[31:24] = 8'd5; m_in[31:24] = 8'd5; req[3] = 1;
    wait_acks(base + 1, 150, "timeout");
    chk("to_lane", 32'(ackq[base]), 3); chk("to_err", 32'(err), 1);
    chk("to_res", 32'(result), 0); chk("to_latency", 32'(ak_cyc - st_cyc), 32'(TO + 1));
    lat_cfg = 3; base = ackq.size(); q_in[7:0] = 8'd3; m_in[7:0] = 8'hFE; req[0] = 1;
    wait_acks(base + 1, 40, "after_to");
    chk("after_to_err", 32'(err), 0); chk("after_to_res", 32'(result), 32'hFFFA);
    drain(20);

    // reset in the middle of WAIT
    lat_cfg = 0; ns0 = nstart; q_in[15:8] = 8'd4; m_in[15:8] = 8'd4; req[1] = 1;
    c = 0;
    while (nstart == ns0 && c < 20) begin step(); c++; end
    chk("mid_started", 32'(nstart - ns0), 1);
    repeat (5) step();
    @(negedge clk); #2 rst_n = 0; #1;
    chk("mid_ack", 32'(ack), 0); chk("mid_busy", 32'(busy), 0);
    chk("mid_err", 32'(err), 0); chk("mid_res", 32'(result), 0);
    chk("mid_start", 32'(mul_start), 0); chk("mid_q", 32'(mul_q), 0); chk("mid_m", 32'(mul_m), 0);
    base = ackq.size();
    q_in[23:16] = 8'd9; m_in[23:16] = 8'd9; req = 4'b0100;
    repeat (3) step();
    lat_cfg = 2; rst_n = 1;
    wait_acks(base + 1, 40, "post_rst");
    chk("post_rst_lane", 32'(ackq[base]), 2); chk("post_rst_res", 32'(result), 32'd81);
    repeat (5) step();
    chk("post_rst_single", 32'(ackq.size()), 32'(base + 1));

    // randomized traffic, latencies, timeouts and spurious done
    rand_en = 1; lat_rand = 1; spur_en = 1;
    repeat (1500) step();
    rand_en = 0; lat_rand = 0; lat_cfg = 2; spur_en = 0;
    drain(600);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
